// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the 32-point FFT stream controller: controller
// states and default frame geometry.
package fft_ctrl_pkg;

    localparam int NFFT_DEF = 32;  // points per frame (power of two)
    localparam int LOGN_DEF = 5;   // log2(NFFT_DEF), width of sample indices
    localparam int FCW_DEF  = 8;   // width of the wrapping frame counters

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/fft_out_tagger.sv
// Output-side tagging for the FFT datapath. Arms on the RDY pulse of the
// last reordering buffer, then counts ED cycles to produce valid/first/last,
// the output sample index and the number of completed output frames.
module fft_out_tagger
    import fft_ctrl_pkg::*;
#(
    parameter int NFFT = NFFT_DEF,
    parameter int LOGN = LOGN_DEF,
    parameter int FCW  = FCW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start_i,
    input  logic            buf_rdy_i,
    input  logic            ed_i,
    output logic            out_valid_o,
    output logic            out_first_o,
    output logic            out_last_o,
    output logic [LOGN-1:0] out_idx_o,
    output logic [FCW-1:0]  out_frames_o
);

    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(NFFT - 1);

    logic            out_armed_q, out_armed_d;
    logic [LOGN-1:0] out_idx_q,   out_idx_d;
    logic [FCW-1:0]  out_frames_q, out_frames_d;

    assign out_valid_o  = out_armed_q & ed_i;
    assign out_first_o  = out_valid_o & (out_idx_q == '0);
    assign out_last_o   = out_valid_o & (out_idx_q == IDX_LAST);
    assign out_idx_o    = out_idx_q;
    assign out_frames_o = out_frames_q;

    // Next-state for the arm flag, output index and output frame count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        out_armed_d  = out_armed_q;
        out_idx_d    = out_idx_q;
        out_frames_d = out_frames_q;

        // START re-aligns the datapath, so it overrides a coincident RDY.
        if (start_i) begin
            out_armed_d = 1'b0;
        end else if (buf_rdy_i) begin
            out_armed_d = 1'b1;
        end

        if (start_i) begin
            out_idx_d = '0;
        end else if (out_valid_o) begin
            out_idx_d = out_idx_q + 1'b1;
        end

        if (out_last_o) begin
            out_frames_d = out_frames_q + 1'b1;
        end
    end

    // Tagger state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (RST) begin
            out_armed_q  <= 1'b0;
            out_idx_q    <= '0;
            out_frames_q <= '0;
        end else begin
            out_armed_q  <= out_armed_d;
            out_idx_q    <= out_idx_d;
            out_frames_q <= out_frames_d;
        end
    end

endmodule

// File: rtl/fft32_stream_ctrl.sv
// Sequencer for the 32-point pipelined FFT datapath. Turns a valid/ready
// sample stream into START/ED, frames input into NFFT-sample blocks,
// flushes the pipeline with zero samples at end of stream and tags outputs.
// Optional build macro: FFT_CTRL_SYNC_CHECK_EN enables IN_LAST framing checks
// (sticky ERR plus datapath re-alignment); without it IN_LAST is ignored.
module fft32_stream_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NFFT = NFFT_DEF,
    parameter int LOGN = LOGN_DEF,
    parameter int FCW  = FCW_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            IN_VALID,
    input  logic            IN_LAST,
    output logic            IN_READY,
    output logic            ZERO_SEL,
    output logic            START,
    output logic            ED,
    input  logic            BUF_RDY,
    output logic            OUT_VALID,
    output logic            OUT_FIRST,
    output logic            OUT_LAST,
    output logic [LOGN-1:0] OUT_IDX,
    output logic [FCW-1:0]  FRAME_CNT,
    output logic            BUSY,
    output logic            ERR
);

    localparam logic [LOGN-1:0] IDX_LAST = LOGN'(NFFT - 1);

    state_e          state_q, state_d;
    logic [LOGN-1:0] in_idx_q, in_idx_d;
    logic [FCW-1:0]  in_frames_q, in_frames_d;
    logic            start_q, busy_q, zero_sel_q;

    logic            ed, in_ready;
    logic            accept, at_last, sync_err;
    logic [FCW-1:0]  out_frames, pending;
    logic            out_last;
    logic [LOGN-1:0] out_idx;
    logic            flush_done;

    assign accept  = (state_q == RUN) & IN_VALID;
    assign at_last = (in_idx_q == IDX_LAST);

`ifdef FFT_CTRL_SYNC_CHECK_EN
    logic err_q;

    // Source framing must agree with the local sample index.
    assign sync_err = accept & (IN_LAST != at_last);

    // Sticky framing error, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (sync_err) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    logic unused_in_last;

    assign unused_in_last = IN_LAST;
    assign sync_err       = 1'b0;
    assign ERR            = 1'b0;
`endif

    // Frames still owed to the output side; modular like the counters.
    assign pending = in_frames_q - out_frames;

    // Leave FLUSH on the edge that completes the last owed output frame, so
    // the first IDLE cycle already sees pending==0 and out_idx==0 and no
    // stray ED reaches an armed tagger. The first term covers a flush with
    // nothing outstanding.
    assign flush_done = ((pending == '0) && (out_idx == '0)) ||
                        (out_last && (pending == FCW'(1)));

    // Controller FSM next-state, input counters and combinational controls.
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        in_frames_d = in_frames_q;
        ed          = 1'b0;
        in_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                in_idx_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                ed       = IN_VALID;
                if (accept) begin
                    in_idx_d = in_idx_q + 1'b1;
                    // A broken frame is not counted; ARM re-aligns instead.
                    if (at_last && !sync_err) begin
                        in_frames_d = in_frames_q + 1'b1;
                    end
                end
                if (sync_err) begin
                    state_d = ARM;
                end else if (!EN && ((!accept && (in_idx_q == '0)) ||
                                     (accept && at_last))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                ed = 1'b1;
                if (flush_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered controls; START is high for the ARM cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            in_idx_q    <= '0;
            in_frames_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            zero_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            in_frames_q <= in_frames_d;
            start_q     <= (state_d == ARM);
            busy_q      <= (state_d != IDLE);
            zero_sel_q  <= (state_d == FLUSH);
        end
    end

    fft_out_tagger #(
        .NFFT (NFFT),
        .LOGN (LOGN),
        .FCW  (FCW)
    ) u_tagger (
        .CLK          (CLK),
        .RST          (RST),
        .start_i      (start_q),
        .buf_rdy_i    (BUF_RDY),
        .ed_i         (ed),
        .out_valid_o  (OUT_VALID),
        .out_first_o  (OUT_FIRST),
        .out_last_o   (out_last),
        .out_idx_o    (out_idx),
        .out_frames_o (out_frames)
    );

    assign ED        = ed;
    assign IN_READY  = in_ready;
    assign START     = start_q;
    assign BUSY      = busy_q;
    assign ZERO_SEL  = zero_sel_q;
    assign OUT_LAST  = out_last;
    assign OUT_IDX   = out_idx;
    assign FRAME_CNT = out_frames;

endmodule

// File: tb/tb_fft32_stream_ctrl.sv
// Directed bench for fft32_stream_ctrl. The datapath is modelled as a fixed
// latency in ED cycles: BUF_RDY is pulsed with the accept of sample L-1, so
// output n carries the tag of accepted sample n, which is pushed to the
// scoreboard when the sample is driven.
module tb_fft32_stream_ctrl;

    localparam int NFFT = 32;
    localparam int LOGN = 5;
    localparam int FCW  = 8;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            EN = 1'b0;
    logic            IN_VALID = 1'b0;
    logic            IN_LAST = 1'b0;
    logic            BUF_RDY = 1'b0;
    logic            IN_READY, ZERO_SEL, START, ED;
    logic            OUT_VALID, OUT_FIRST, OUT_LAST, BUSY, ERR;
    logic [LOGN-1:0] OUT_IDX;
    logic [FCW-1:0]  FRAME_CNT;

    typedef struct packed {
        logic [LOGN-1:0] idx;
        logic            first;
        logic            last;
    } tag_t;

    tag_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_n = 0;
    int   out_seen = 0;
    int   acc_seen = 0;

    fft32_stream_ctrl #(.NFFT(NFFT), .LOGN(LOGN), .FCW(FCW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .IN_LAST   (IN_LAST),
        .IN_READY  (IN_READY),
        .ZERO_SEL  (ZERO_SEL),
        .START     (START),
        .ED        (ED),
        .BUF_RDY   (BUF_RDY),
        .OUT_VALID (OUT_VALID),
        .OUT_FIRST (OUT_FIRST),
        .OUT_LAST  (OUT_LAST),
        .OUT_IDX   (OUT_IDX),
        .FRAME_CNT (FRAME_CNT),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tag();
        tag_t t;
        int   p;
        p       = exp_n % NFFT;
        t.idx   = LOGN'(p);
        t.first = (p == 0);
        t.last  = (p == NFFT - 1);
        sb_q.push_back(t);
        exp_n++;
    endtask

    // One clock cycle: monitor outputs at the falling edge, return 1 ns after
    // the rising edge so the caller can drive the next cycle's inputs.
    task automatic tick();
        tag_t t;
        @(negedge CLK);
        if (!RST) begin
            if (IN_VALID && IN_READY) acc_seen++;
            if (OUT_VALID) begin
                out_seen++;
                check("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    t = sb_q.pop_front();
                    check("out_idx",   32'(OUT_IDX),   32'(t.idx));
                    check("out_first", 32'(OUT_FIRST), 32'(t.first));
                    check("out_last",  32'(OUT_LAST),  32'(t.last));
                end
            end else begin
                check("tag_quiet", 32'({OUT_FIRST, OUT_LAST}), 0);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; BUF_RDY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        sb_q.delete();
        exp_n = 0; out_seen = 0; acc_seen = 0;
    endtask

    task automatic arm();
        int n = 0;
        EN = 1'b1;
        do begin
            tick();
            n++;
        end while (!START && n < 10);
        check("arm_latency", 32'(n), 1);
        tick();
        check("run_ready", 32'(IN_READY), 1);
    endtask

    task automatic accept(input logic last, input logic rdy, input logic push);
        int n = 0;
        while (!IN_READY && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(IN_READY), 1);
        IN_VALID = 1'b1; IN_LAST = last; BUF_RDY = rdy;
        if (push) push_tag();
        tick();
        IN_VALID = 1'b0; IN_LAST = 1'b0; BUF_RDY = 1'b0;
    endtask

    initial begin
        int n;
        int starts;
        logic zero_seen;

        // Reset with EN and IN_VALID held high: everything stays quiet.
        RST = 1'b1; EN = 1'b1; IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", 32'({IN_READY, ZERO_SEL, START, ED, OUT_VALID, OUT_FIRST,
                                     OUT_LAST, OUT_IDX, FRAME_CNT, BUSY, ERR}), 0);
        end
        RST = 1'b0;
        tick();
        check("arm_ctrl", 32'({START, BUSY, IN_READY, ED}), 32'b1100);
        starts = int'(START);
        IN_VALID = 1'b0;
        tick();
        check("run_ctrl", 32'({START, BUSY, IN_READY, ED}), 32'b0110);
        for (int i = 0; i < 4; i++) begin
            tick();
            starts += int'(START);
        end
        check("start_once", 32'(starts), 1);

        // Two contiguous frames, latency 1; EN re-raised during FLUSH.
        do_reset();
        arm();
        for (int k = 0; k < 64; k++) begin
            if (k == 63) EN = 1'b0;
            accept((k % NFFT) == NFFT - 1, k == 0, 1'b1);
        end
        EN = 1'b1; IN_VALID = 1'b1;
        n = 0; zero_seen = 1'b0;
        while (BUSY && n < 50) begin
            if (ZERO_SEL) begin
                zero_seen = 1'b1;
                check("flush_no_ready", 32'(IN_READY), 0);
                check("flush_ed", 32'(ED), 1);
            end
            tick();
            n++;
        end
        check("flush2_idle", 32'(BUSY), 0);
        check("flush2_zero_sel", 32'(zero_seen), 1);
        check("frame_cnt_2", 32'(FRAME_CNT), 2);
        check("out_count_64", 32'(out_seen), 64);
        check("acc_count_64", 32'(acc_seen), 64);
        check("sb_drained_2", 32'(sb_q.size()), 0);
        n = 0;
        while (!START && n < 10) begin
            tick();
            n++;
        end
        check("rearm_start", 32'(START), 1);
        IN_VALID = 1'b0;

        // IN_VALID toggling: ED follows IN_VALID, in_idx wraps after 32 accepts.
        do_reset();
        arm();
        for (int i = 0; i < 64; i++) begin
            IN_VALID = (i % 2 == 0);
            IN_LAST  = (i == 62);
            #1;
            check("ed_follows_valid", 32'(ED), 32'(i % 2 == 0));
            tick();
            if (i == 60) check("in_idx_31", 32'(dut.in_idx_q), 31);
        end
        IN_VALID = 1'b0; IN_LAST = 1'b0;
        check("in_idx_wrap", 32'(dut.in_idx_q), 0);
        check("in_frames_1", 32'(dut.in_frames_q), 1);
        check("acc_count_32", 32'(acc_seen), 32);
        check("no_err_aligned", 32'(ERR), 0);

        // EN dropped after sample 10 of frame 3, latency 6, IN_VALID held in FLUSH.
        do_reset();
        arm();
        for (int k = 0; k < 96; k++) begin
            if (k == 74) EN = 1'b0;
            accept((k % NFFT) == NFFT - 1, k == 5, 1'b1);
        end
        IN_VALID = 1'b1;
        n = 0; zero_seen = 1'b0;
        while (BUSY && n < 100) begin
            if (ZERO_SEL) begin
                zero_seen = 1'b1;
                check("flush_no_ready", 32'(IN_READY), 0);
            end
            tick();
            n++;
        end
        IN_VALID = 1'b0;
        check("flush3_idle", 32'(BUSY), 0);
        check("flush3_zero_sel", 32'(zero_seen), 1);
        check("frame_cnt_3", 32'(FRAME_CNT), 3);
        check("acc_count_96", 32'(acc_seen), 96);
        check("out_count_96", 32'(out_seen), 96);
        check("sb_drained_3", 32'(sb_q.size()), 0);
        tick();
        tick();
        check("idle_stays", 32'({BUSY, START, ZERO_SEL}), 0);

        // IN_LAST on sample 20: re-align only when the framing check is built in.
        do_reset();
        arm();
        for (int k = 0; k < 20; k++) accept(k == 19, 1'b0, 1'b0);
`ifdef FFT_CTRL_SYNC_CHECK_EN
        check("sync_err_set", 32'(ERR), 1);
        check("sync_restart", 32'(START), 1);
        tick();
        check("sync_idx_zero", 32'(dut.in_idx_q), 0);
        for (int k = 0; k < 32; k++) accept(k == 31, 1'b0, 1'b0);
        check("sync_frames", 32'(dut.in_frames_q), 1);
        check("sync_err_sticky", 32'(ERR), 1);
`else
        check("sync_err_off", 32'(ERR), 0);
        check("sync_no_restart", 32'(START), 0);
        check("sync_idx_20", 32'(dut.in_idx_q), 20);
        for (int k = 20; k < 32; k++) accept(k == 31, 1'b0, 1'b0);
        check("sync_frames", 32'(dut.in_frames_q), 1);
        check("sync_err_still_off", 32'(ERR), 0);
`endif

        // BUF_RDY coinciding with START: START wins, outputs wait for next RDY.
        do_reset();
        EN = 1'b1;
        tick();
        check("arm_for_collision", 32'(START), 1);
        BUF_RDY = 1'b1;
        tick();
        BUF_RDY = 1'b0;
        check("start_beats_rdy", 32'(dut.u_tagger.out_armed_q), 0);
        for (int k = 0; k < 5; k++) accept(1'b0, 1'b0, 1'b0);
        check("no_out_unarmed", 32'(out_seen), 0);
        accept(1'b0, 1'b1, 1'b0);
        accept(1'b0, 1'b0, 1'b1);
        accept(1'b0, 1'b0, 1'b1);
        check("out_after_rdy", 32'(out_seen), 2);
        check("sb_drained_6", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
